// File: rtl/kw_pkg.sv
// Shared keyword definitions for the post-Viterbi decision logic
// and the LED controller that consumes keyword_index.
package kw_pkg;

    localparam int KW_W = 4;
    localparam logic [KW_W-1:0] KW_NONE = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HOLD,
        REARM
    } kw_dec_state_t;

endpackage

// File: rtl/kw_hold_timer.sv
// Loadable down-counter; done is high for the one cycle in which
// an active count reaches zero, after which the timer goes idle.
module kw_hold_timer #(
    parameter int WIDTH = 1,
    parameter int LOAD  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    logic [WIDTH-1:0] count;
    logic             active;

    // Reload on request, otherwise count down until zero and stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= WIDTH'(LOAD);
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = active && (count == '0);

endmodule

// File: rtl/keyword_decision.sv
// Post-Viterbi decision: thresholds frame scores, confirms a keyword
// over consecutive frames, then holds keyword_index for a fixed time.
module keyword_decision
    import kw_pkg::*;
#(
    parameter int SCORE_W        = 16,
    parameter int THRESH         = 1000,
    parameter int NUM_KW         = 10,
    parameter int CONFIRM_FRAMES = 3,
    parameter int HOLD_CYCLES    = 10_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic [KW_W-1:0]    frame_kw,
    input  logic [SCORE_W-1:0] frame_score,
    output logic [KW_W-1:0]    keyword_index,
    output logic               kw_valid,
    output logic [7:0]         det_count
);

    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic ONE_FRAME = (CONFIRM_FRAMES == 1);

    kw_dec_state_t   state;
    logic [KW_W-1:0] cand;
    logic [3:0]      cnt;
    logic [3:0]      cnt_inc;
    logic            xfer;
    logic            hit;
    logic            same;
    logic            detect;
    logic            done;
    logic            expire;

    assign frame_ready = ~rst;
    assign xfer        = frame_valid & frame_ready;
    assign hit         = xfer
                         && (frame_kw != KW_NONE)
                         && (32'(frame_kw) < NUM_KW)
                         && (frame_score >= SCORE_W'(THRESH));
    assign same        = (frame_kw == cand);
    assign cnt_inc     = cnt + 4'd1;
    assign expire      = (state == HOLD) && done;

    // Decide whether the current transfer completes a detection.
    always_comb begin
        detect = 1'b0;
        unique case (state)
            IDLE:    detect = hit && ONE_FRAME;
            CONFIRM: detect = hit && same
                              && (cnt_inc == 4'(CONFIRM_FRAMES));
            REARM:   detect = hit && !same && ONE_FRAME;
            default: detect = 1'b0;
        endcase
    end

    kw_hold_timer #(
        .WIDTH (TW),
        .LOAD  (HOLD_CYCLES - 1)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (detect),
        .done (done)
    );

    // Decision FSM with registered outputs; expiry wins over frames in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cand          <= KW_NONE;
            cnt           <= '0;
            keyword_index <= KW_NONE;
            kw_valid      <= 1'b0;
            det_count     <= '0;
        end else begin
            kw_valid <= 1'b0;
            if (detect) begin
                state         <= HOLD;
                cand          <= frame_kw;
                cnt           <= '0;
                keyword_index <= frame_kw;
                kw_valid      <= 1'b1;
                if (det_count != 8'hFF) begin
                    det_count <= det_count + 8'd1;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (hit) begin
                            cand  <= frame_kw;
                            cnt   <= 4'd1;
                            state <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (hit && same) begin
                            cnt <= cnt_inc;
                        end else if (hit) begin
                            cand <= frame_kw;
                            cnt  <= 4'd1;
                        end else if (xfer) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (expire) begin
                            keyword_index <= KW_NONE;
                            state         <= REARM;
                        end
                    end
                    REARM: begin
                        if (hit && !same) begin
                            cand  <= frame_kw;
                            cnt   <= 4'd1;
                            state <= CONFIRM;
                        end else if (xfer && !hit) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keyword_decision.sv
// Directed bench for keyword_decision with a detection scoreboard;
// a second instance covers the single-frame confirm build.
module tb_keyword_decision;
    import kw_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  frame_kw;
    logic [15:0] frame_score;
    logic [3:0]  keyword_index;
    logic        kw_valid;
    logic [7:0]  det_count;

    logic        f1_valid;
    logic        f1_ready;
    logic [3:0]  f1_kw;
    logic [15:0] f1_score;
    logic [3:0]  idx1;
    logic        kv1;
    logic [7:0]  dc1;

    int          total = 0;
    int          bad   = 0;
    int          n;
    logic [3:0]  q[$];
    logic [3:0]  q1[$];
    logic [3:0]  e0;
    logic [3:0]  e1;

    always #5 clk = ~clk;

    keyword_decision #(
        .SCORE_W(16), .THRESH(1000), .NUM_KW(10),
        .CONFIRM_FRAMES(3), .HOLD_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_kw(frame_kw), .frame_score(frame_score),
        .keyword_index(keyword_index), .kw_valid(kw_valid),
        .det_count(det_count)
    );

    keyword_decision #(
        .SCORE_W(16), .THRESH(1000), .NUM_KW(10),
        .CONFIRM_FRAMES(1), .HOLD_CYCLES(2)
    ) dut1 (
        .clk(clk), .rst(rst),
        .frame_valid(f1_valid), .frame_ready(f1_ready),
        .frame_kw(f1_kw), .frame_score(f1_score),
        .keyword_index(idx1), .kw_valid(kv1),
        .det_count(dc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cyc);
        repeat (cyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] kw, input logic [15:0] sc);
        frame_valid = 1'b1;
        frame_kw    = kw;
        frame_score = sc;
        tick(1);
        frame_valid = 1'b0;
        frame_kw    = 4'd0;
        frame_score = 16'd0;
    endtask

    task automatic send1(input logic [3:0] kw, input logic [15:0] sc);
        f1_valid = 1'b1;
        f1_kw    = kw;
        f1_score = sc;
        tick(1);
        f1_valid = 1'b0;
        f1_kw    = 4'd0;
        f1_score = 16'd0;
    endtask

    task automatic wait_idx0(output int cyc);
        cyc = 0;
        while (keyword_index != 4'd0 && cyc < 100) begin
            cyc++;
            tick(1);
        end
    endtask

    // Scoreboard: every kw_valid pulse must match a queued detection.
    always @(negedge clk) begin
        if (kv1 === 1'b1 || kw_valid === 1'b1) begin
            if (kw_valid === 1'b1) begin
                total++;
                assert (q.size() != 0) else begin
                    bad++;
                    $error("FAIL spurious_kw_valid observed=%0d expected=none",
                           keyword_index);
                end
                if (q.size() != 0) begin
                    e0 = q.pop_front();
                    total++;
                    assert (keyword_index === e0) else begin
                        bad++;
                        $error("FAIL det_index observed=%0d expected=%0d",
                               keyword_index, e0);
                    end
                end
            end
            if (kv1 === 1'b1) begin
                total++;
                assert (q1.size() != 0) else begin
                    bad++;
                    $error("FAIL spurious_kv1 observed=%0d expected=none", idx1);
                end
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    total++;
                    assert (idx1 === e1) else begin
                        bad++;
                        $error("FAIL det1_index observed=%0d expected=%0d",
                               idx1, e1);
                    end
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        frame_valid = 1'b0;
        frame_kw    = 4'd0;
        frame_score = 16'd0;
        f1_valid    = 1'b0;
        f1_kw       = 4'd0;
        f1_score    = 16'd0;
        #12;
        chk("rst_index", keyword_index, 0);
        chk("rst_kw_valid", kw_valid, 0);
        chk("rst_det_count", det_count, 0);
        chk("rst_ready", frame_ready, 0);
        rst = 1'b0;
        tick(1);
        chk("ready_after_rst", frame_ready, 1);

        // confirm path
        send(5, 1200);
        send(5, 1200);
        chk("no_early_det", keyword_index, 0);
        q.push_back(5);
        send(5, 1200);
        chk("kw_valid_latency", kw_valid, 1);
        wait_idx0(n);
        chk("hold_len_1", n, 20);
        chk("det_count_1", det_count, 1);

        // retrigger suppression
        repeat (4) send(5, 1200);
        chk("rearm_stays", dut.state, REARM);
        send(0, 4000);
        chk("rearm_to_idle", dut.state, IDLE);
        send(5, 1200);
        send(5, 1200);
        q.push_back(5);
        send(5, 1200);
        wait_idx0(n);
        chk("hold_len_2", n, 20);
        chk("det_count_2", det_count, 2);

        // threshold and range
        for (int i = 0; i < 3; i++) begin
            send(5, 999);
            chk("below_thresh", dut.state == HOLD, 0);
            send(12, 4000);
            chk("kw_out_of_range", dut.state == HOLD, 0);
            send(0, 4000);
            chk("kw_filler", keyword_index, 0);
        end
        send(5, 1000);
        chk("thresh_equal_hit", dut.state, CONFIRM);
        send(0, 0);

        // candidate switch and break
        send(3, 2000);
        send(3, 2000);
        send(7, 2000);
        send(7, 2000);
        q.push_back(7);
        send(7, 2000);
        chk("switch_index", keyword_index, 7);
        wait_idx0(n);
        send(0, 0);
        send(3, 2000);
        send(3, 2000);
        send(3, 10);
        send(3, 2000);
        send(3, 2000);
        chk("break_no_det", dut.state, CONFIRM);
        send(0, 0);
        chk("det_count_3", det_count, 3);

        // expiry collision
        send(5, 2000);
        send(5, 2000);
        q.push_back(5);
        send(5, 2000);
        tick(19);
        chk("last_hold_cycle", keyword_index, 5);
        send(9, 2000);
        chk("expired_index", keyword_index, 0);
        chk("expiry_discard", dut.state, REARM);
        send(9, 2000);
        send(9, 2000);
        chk("post_expiry_cnt", dut.state, CONFIRM);
        q.push_back(9);
        send(9, 2000);
        chk("det_count_5", det_count, 5);

        // reset during HOLD
        tick(3);
        chk("held_before_rst", keyword_index, 9);
        #2;
        rst = 1'b1;
        #1;
        chk("async_index", keyword_index, 0);
        chk("async_kw_valid", kw_valid, 0);
        chk("async_ready", frame_ready, 0);
        chk("async_det_count", det_count, 0);
        chk("async_state", dut.state, IDLE);
        #1;
        rst = 1'b0;
        tick(1);
        chk("ready_again", frame_ready, 1);

        // single-frame build and saturation
        for (int i = 0; i < 300; i++) begin
            q1.push_back(4'(1 + i % 9));
            send1(4'(1 + i % 9), 2000);
            chk("cf1_index", idx1, 1 + i % 9);
            if (i == 0) chk("cf1_count_first", dc1, 1);
            if (i == 254) chk("cf1_count_255", dc1, 255);
            tick(2);
            send1(0, 0);
        end
        chk("cf1_saturated", dc1, 255);

        tick(2);
        chk("queue_drained", q.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
